// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - sequence monitor for a free-running up-counter
// Optional build macro: COUNTER_CHECKER_STICKY_EN (a break while locked latches
// a FAULT state until reset instead of re-acquiring).
module counter_checker #(
  parameter int BW       = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERR_BW   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BW-1:0]     counter_val_i,
  output logic              locked_o,
  output logic              err_o,
  output logic [ERR_BW-1:0] err_cnt_o
);

  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [RW-1:0]     LOCK_R  = RW'(LOCK_CNT);
  localparam logic [ERR_BW-1:0] ERR_MAX = {ERR_BW{1'b1}};

`ifdef COUNTER_CHECKER_STICKY_EN
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
`endif

  state_t        state;
  logic [BW-1:0] prev;
  logic [RW-1:0] run;
  logic [BW-1:0] exp_val;
  logic [RW-1:0] run_inc;
  logic          match;

  // Expected next sample wraps naturally from all-ones to zero.
  assign exp_val = prev + {{(BW-1){1'b0}}, 1'b1};
  assign run_inc = run + {{(RW-1){1'b0}}, 1'b1};
  assign match   = (counter_val_i == exp_val);

  // Acquire/lock/break state machine; every output is a register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      prev      <= '0;
      run       <= '0;
      locked_o  <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      err_o <= 1'b0;
      prev  <= counter_val_i;
      case (state)
        IDLE: begin
          run   <= '0;
          state <= ACQ;
        end
        ACQ: begin
          if (match) begin
            run <= run_inc;
            if (run_inc == LOCK_R) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end
          end else begin
            run <= '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_o    <= 1'b1;
            locked_o <= 1'b0;
            run      <= '0;
            if (err_cnt_o != ERR_MAX) begin
              err_cnt_o <= err_cnt_o + {{(ERR_BW-1){1'b0}}, 1'b1};
            end
`ifdef COUNTER_CHECKER_STICKY_EN
            state <= FAULT;
`else
            state <= ACQ;
`endif
          end
        end
`ifdef COUNTER_CHECKER_STICKY_EN
        FAULT: begin
          // Terminal until reset: no re-acquisition, counter frozen.
          locked_o <= 1'b0;
          run      <= '0;
        end
`endif
        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
          run      <= '0;
        end
      endcase
    end
  end

endmodule
